// File: rtl/mod_symbol_sequencer_pkg.sv
// Shared definitions for the modulator symbol sequencer: symbol codes for the
// 4:1 modulator mux, FSM state type and counter sizing helper.
package mod_pkg;

    localparam int SEL_W = 2;

    // Symbol codes select mux inputs in0..in3
    localparam logic [SEL_W-1:0] SYM_0 = 2'd0;
    localparam logic [SEL_W-1:0] SYM_1 = 2'd1;
    localparam logic [SEL_W-1:0] SYM_2 = 2'd2;
    localparam logic [SEL_W-1:0] SYM_3 = 2'd3;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Counter width for a modulus n; a 1-bit counter is kept even when n==1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_symbol_sequencer_timer.sv
// Symbol hold prescaler: counts SYM_DIV clocks per symbol and flags the
// final clock of each symbol period.
module mod_symbol_timer
    import mod_pkg::*;
#(
    parameter int unsigned SYM_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_run,
    output logic o_last
);

    localparam int unsigned          DIV_W    = cnt_width(SYM_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SYM_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (i_restart || (i_run && o_last)) begin
            r_div_cnt <= '0;
        end else if (i_run) begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_last = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/mod_symbol_sequencer.sv
// Serializes handshaked data words into 2-bit symbols, MSB pair first, each held
// SYM_DIV clocks on the modulator mux select; parks on IDLE_SEL between words.
module mod_symbol_sequencer
    import mod_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       SYM_DIV  = 4,
    parameter logic [SEL_W-1:0]  IDLE_SEL = SYM_0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              sym_strobe,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      N        = DATA_W / 2;
    localparam int unsigned      IDX_W    = cnt_width(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [IDX_W-1:0]   r_sym_idx;
    logic [SEL_W-1:0]   r_sel;
    logic               r_strobe;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [DATA_W-1:0]  w_shift_adv;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_strobe_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_last;
    logic               w_word_end;
    logic               w_accept;

    mod_symbol_timer #(
        .SYM_DIV (SYM_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_accept),
        .i_run     (r_state == SHIFT),
        .o_last    (w_last)
    );

    assign w_word_end  = (r_state == SHIFT) && w_last && (r_sym_idx == IDX_LAST);
    assign in_ready    = !rst && ((r_state == IDLE) || w_word_end);
    assign w_accept    = in_valid && in_ready;
    assign w_shift_adv = r_shift << SEL_W;

    // in_ready is only high in IDLE or on the last clock of a word, so any
    // accept is a fresh load regardless of state (covers the gapless reload).
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_sym_idx;
        w_sel_nxt    = r_sel;
        w_strobe_nxt = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        if (w_accept) begin
            w_state_nxt  = SHIFT;
            w_shift_nxt  = in_data;
            w_idx_nxt    = '0;
            w_sel_nxt    = in_data[DATA_W-1 -: SEL_W];
            w_strobe_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_sel_nxt  = IDLE_SEL;
                    w_busy_nxt = 1'b0;
                end
                SHIFT: begin
                    if (w_last) begin
                        if (r_sym_idx == IDX_LAST) begin
                            w_state_nxt = IDLE;
                            w_shift_nxt = '0;
                            w_idx_nxt   = '0;
                            w_sel_nxt   = IDLE_SEL;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_shift_nxt  = w_shift_adv;
                            w_idx_nxt    = r_sym_idx + 1'b1;
                            w_sel_nxt    = w_shift_adv[DATA_W-1 -: SEL_W];
                            w_strobe_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = IDLE_SEL;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_sym_idx <= '0;
            r_sel     <= IDLE_SEL;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_sym_idx <= w_idx_nxt;
            r_sel     <= w_sel_nxt;
            r_strobe  <= w_strobe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign sel        = r_sel;
    assign sym_strobe = r_strobe;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_mod_symbol_sequencer.sv
// Directed bench for mod_symbol_sequencer: SYM_DIV=4 and SYM_DIV=1 instances,
// observed outputs packed as {sel, sym_strobe, busy, done, in_ready}.
module tb_mod_symbol_sequencer;

    localparam logic [5:0] V_RST  = 6'b00_0_0_0_0;
    localparam logic [5:0] V_IDLE = 6'b00_0_0_0_1;
    localparam logic [5:0] V_DONE = 6'b00_0_0_1_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic       sym_strobe;
    logic       busy;
    logic       done;

    logic [7:0] in_data1;
    logic       in_valid1;
    logic       in_ready1;
    logic [1:0] sel1;
    logic       sym_strobe1;
    logic       busy1;
    logic       done1;

    int n_checks = 0;
    int n_errors = 0;

    wire [5:0] obs  = {sel,  sym_strobe,  busy,  done,  in_ready};
    wire [5:0] obs1 = {sel1, sym_strobe1, busy1, done1, in_ready1};

    mod_symbol_sequencer #(
        .DATA_W  (8),
        .SYM_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .done       (done)
    );

    mod_symbol_sequencer #(
        .DATA_W  (8),
        .SYM_DIV (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .sel        (sel1),
        .sym_strobe (sym_strobe1),
        .busy       (busy1),
        .done       (done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {sel,stb,busy,done,rdy}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected outputs in cycle j (1-based, j=1 is the clock after accept) of an 8-bit word
    function automatic logic [5:0] exp_word(input logic [7:0] w, input int div, input int j);
        int         s;
        logic [1:0] sy;
        s  = (j - 1) / div;
        sy = w[7 - 2*s -: 2];
        return {sy, ((j - 1) % div) == 0, 1'b1, 1'b0, j == 4*div};
    endfunction

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        in_data1  = '0;
        in_valid1 = 1'b0;

        // Reset held, then released
        repeat (3) @(negedge clk);
        check("rst_hold", obs, V_RST);
        check("rst_hold_div1", obs1, V_RST);
        rst = 1'b0;
        #1;
        check("rst_release", obs, V_IDLE);

        // Single word 0xB4 -> 2,3,1,0
        in_data  = 8'hB4;
        in_valid = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 1) in_valid = 1'b0;
            check($sformatf("single_c%0d", j), obs, exp_word(8'hB4, 4, j));
        end
        tick();
        check("single_done", obs, V_DONE);
        tick();
        check("single_idle", obs, V_IDLE);

        // Back-to-back 0xB4 then 0x1B with valid held
        in_data  = 8'hB4;
        in_valid = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            tick();
            check($sformatf("b2b_c%0d", j), obs,
                  (j <= 16) ? exp_word(8'hB4, 4, j) : exp_word(8'h1B, 4, j - 16));
            if (j == 1)  in_data  = 8'h1B;
            if (j == 17) in_valid = 1'b0;
        end
        tick();
        check("b2b_done", obs, V_DONE);
        tick();
        check("b2b_idle", obs, V_IDLE);

        // Reset during the third symbol of 0xB4
        in_data  = 8'hB4;
        in_valid = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 1) in_valid = 1'b0;
            check($sformatf("midrst_c%0d", j), obs, exp_word(8'hB4, 4, j));
        end
        rst = 1'b1;
        #1;
        check("midrst_async", obs, V_RST);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release", obs, V_IDLE);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check($sformatf("midrst_nodone_c%0d", j), obs, V_IDLE);
        end
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (j == 1) in_valid = 1'b0;
            check($sformatf("ff_c%0d", j), obs, exp_word(8'hFF, 4, j));
        end
        tick();
        check("ff_done", obs, V_DONE);

        // SYM_DIV=1: 0x6C -> 1,2,3,0 on consecutive clocks
        in_data1  = 8'h6C;
        in_valid1 = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 1) in_valid1 = 1'b0;
            check($sformatf("div1_c%0d", j), obs1, exp_word(8'h6C, 1, j));
        end
        tick();
        check("div1_done", obs1, V_DONE);

        // Valid held mid-word with changing data: only the last-cycle value is taken
        in_data  = 8'hB4;
        in_valid = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            tick();
            check($sformatf("hold_c%0d", j), obs,
                  (j <= 16) ? exp_word(8'hB4, 4, j) : exp_word(8'hE1, 4, j - 16));
            if (j < 16)       in_data  = 8'h55 ^ 8'(j);
            else if (j == 16) in_data  = 8'hE1;
            if (j == 17)      in_valid = 1'b0;
        end
        tick();
        check("hold_done", obs, V_DONE);
        tick();
        check("hold_idle", obs, V_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
